// File: rtl/decoupled_queue.sv
// Registered ready/valid FIFO: DEPTH entries, one-cycle minimum enq-to-deq latency.
// Back-pressure: enq_ready drops only when full; a same-cycle deq frees the slot for the next cycle.
module decoupled_queue #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       io_enq_ready,
  input  logic                       io_enq_valid,
  input  logic [WIDTH-1:0]           io_enq_bits,
  input  logic                       io_deq_ready,
  output logic                       io_deq_valid,
  output logic [WIDTH-1:0]           io_deq_bits,
  output logic [$clog2(DEPTH+1)-1:0] io_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    enq_ptr;
  logic [PW-1:0]    deq_ptr;
  logic             maybe_full;

  logic             ptr_match;
  logic             empty;
  logic             full;
  logic             do_enq;
  logic             do_deq;
  logic [DW-1:0]    ptr_diff;

  assign ptr_match    = (enq_ptr == deq_ptr);
  assign empty        = ptr_match && !maybe_full;
  assign full         = ptr_match && maybe_full;
  assign io_enq_ready = !full;
  assign io_deq_valid = !empty;
  assign io_deq_bits  = mem[deq_ptr];
  assign do_enq       = io_enq_valid && io_enq_ready;
  assign do_deq       = io_deq_ready && io_deq_valid;

  // Modular difference; when the pointers match the full flag disambiguates 0 vs DEPTH.
  always_comb begin
    ptr_diff = '0;
    if (enq_ptr >= deq_ptr)
      ptr_diff = {1'b0, enq_ptr} - {1'b0, deq_ptr};
    else
      ptr_diff = {1'b0, enq_ptr} + DW'(DEPTH) - {1'b0, deq_ptr};
  end

  assign io_count = full ? CW'(DEPTH) : CW'(ptr_diff);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage is deliberately left out of reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (!reset && do_enq)
      mem[enq_ptr] <= io_enq_bits;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq)
        enq_ptr <= next_ptr(enq_ptr);
      if (do_deq)
        deq_ptr <= next_ptr(deq_ptr);
      if (do_enq != do_deq)
        maybe_full <= do_enq;
    end
  end

endmodule

// File: tb/tb_decoupled_queue.sv
// Directed and model-checked bench for decoupled_queue (WIDTH=8 and WIDTH=1 instances, DEPTH=4).
module tb_decoupled_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         total = 0;
  int         bad = 0;

  logic       enq_ready8;
  logic       enq_valid8 = 1'b0;
  logic [7:0] enq_bits8 = '0;
  logic       deq_ready8 = 1'b0;
  logic       deq_valid8;
  logic [7:0] deq_bits8;
  logic [2:0] count8;

  logic       enq_ready1;
  logic       shim_valid = 1'b0;
  logic [0:0] shim_in_bits = '0;
  logic [0:0] shim_out_bits;
  logic       deq_ready1 = 1'b0;
  logic       deq_valid1;
  logic [0:0] deq_bits1;
  logic [2:0] count1;

  always #5 clk = ~clk;

  // Bench-side stand-in for the +1 shim feeding the WIDTH=1 queue.
  assign shim_out_bits = shim_in_bits + 1'b1;

  decoupled_queue #(.WIDTH(8), .DEPTH(4)) dut8 (
    .clk(clk), .reset(reset),
    .io_enq_ready(enq_ready8), .io_enq_valid(enq_valid8), .io_enq_bits(enq_bits8),
    .io_deq_ready(deq_ready8), .io_deq_valid(deq_valid8), .io_deq_bits(deq_bits8),
    .io_count(count8)
  );

  decoupled_queue #(.WIDTH(1), .DEPTH(4)) dut1 (
    .clk(clk), .reset(reset),
    .io_enq_ready(enq_ready1), .io_enq_valid(shim_valid), .io_enq_bits(shim_out_bits),
    .io_deq_ready(deq_ready1), .io_deq_valid(deq_valid1), .io_deq_bits(deq_bits1),
    .io_count(count1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (enq_ready8 !== 1'b1 || deq_valid8 !== 1'b0 || count8 !== 3'd0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got rdy=%b vld=%b cnt=%0d want rdy=1 vld=0 cnt=0",
                 i, enq_ready8, deq_valid8, count8);
      end
      tick();
    end
  endtask

  task automatic test_fill_hold_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    deq_ready8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq_valid8 = 1'b1;
      enq_bits8  = vals[i];
      tick();
      total++;
      if (count8 !== 3'(i + 1)) begin
        bad++;
        $display("FAIL fill_count i=%0d got=%0d want=%0d", i, count8, i + 1);
      end
    end
    total++;
    if (enq_ready8 !== 1'b0) begin
      bad++;
      $display("FAIL full_enq_ready got=%b want=0", enq_ready8);
    end
    enq_bits8 = 8'h55;
    tick();
    total++;
    if (count8 !== 3'd4 || deq_bits8 !== 8'h11) begin
      bad++;
      $display("FAIL hold_not_stored got cnt=%0d head=%h want cnt=4 head=11", count8, deq_bits8);
    end
    deq_ready8 = 1'b1;
    tick();
    total++;
    if (count8 !== 3'd3 || enq_ready8 !== 1'b1 || deq_bits8 !== 8'h22) begin
      bad++;
      $display("FAIL first_pop got cnt=%0d rdy=%b head=%h want cnt=3 rdy=1 head=22",
               count8, enq_ready8, deq_bits8);
    end
    tick();
    enq_valid8 = 1'b0;
    vals[0] = 8'h33; vals[1] = 8'h44; vals[2] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (deq_valid8 !== 1'b1 || deq_bits8 !== vals[i] || count8 !== 3'(3 - i)) begin
        bad++;
        $display("FAIL drain_order i=%0d got vld=%b head=%h cnt=%0d want vld=1 head=%h cnt=%0d",
                 i, deq_valid8, deq_bits8, count8, vals[i], 3 - i);
      end
      tick();
    end
    total++;
    if (deq_valid8 !== 1'b0 || count8 !== 3'd0) begin
      bad++;
      $display("FAIL drain_empty got vld=%b cnt=%0d want vld=0 cnt=0", deq_valid8, count8);
    end
    deq_ready8 = 1'b0;
  endtask

  task automatic test_stream();
    deq_ready8 = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      enq_valid8 = (i < 16);
      enq_bits8  = 8'(i);
      total++;
      if (i == 0) begin
        if (deq_valid8 !== 1'b0 || count8 !== 3'd0) begin
          bad++;
          $display("FAIL stream_start got vld=%b cnt=%0d want vld=0 cnt=0", deq_valid8, count8);
        end
      end else if (deq_valid8 !== 1'b1 || deq_bits8 !== 8'(i - 1) || count8 !== 3'd1) begin
        bad++;
        $display("FAIL stream i=%0d got vld=%b data=%h cnt=%0d want vld=1 data=%h cnt=1",
                 i, deq_valid8, deq_bits8, count8, 8'(i - 1));
      end
      tick();
    end
    total++;
    if (deq_valid8 !== 1'b0 || count8 !== 3'd0) begin
      bad++;
      $display("FAIL stream_end got vld=%b cnt=%0d want vld=0 cnt=0", deq_valid8, count8);
    end
    enq_valid8 = 1'b0;
    deq_ready8 = 1'b0;
  endtask

  task automatic test_full_simultaneous();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    deq_ready8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq_valid8 = 1'b1;
      enq_bits8  = vals[i];
      tick();
    end
    enq_bits8  = 8'hAA;
    deq_ready8 = 1'b1;
    total++;
    if (count8 !== 3'd4 || enq_ready8 !== 1'b0 || deq_bits8 !== 8'h11) begin
      bad++;
      $display("FAIL simul_pre got cnt=%0d rdy=%b head=%h want cnt=4 rdy=0 head=11",
               count8, enq_ready8, deq_bits8);
    end
    tick();
    deq_ready8 = 1'b0;
    total++;
    if (count8 !== 3'd3 || enq_ready8 !== 1'b1 || deq_bits8 !== 8'h22) begin
      bad++;
      $display("FAIL simul_mid got cnt=%0d rdy=%b head=%h want cnt=3 rdy=1 head=22",
               count8, enq_ready8, deq_bits8);
    end
    tick();
    enq_valid8 = 1'b0;
    total++;
    if (count8 !== 3'd4) begin
      bad++;
      $display("FAIL simul_refill got cnt=%0d want cnt=4", count8);
    end
    vals[0] = 8'h22; vals[1] = 8'h33; vals[2] = 8'h44; vals[3] = 8'hAA;
    deq_ready8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (deq_valid8 !== 1'b1 || deq_bits8 !== vals[i]) begin
        bad++;
        $display("FAIL simul_drain i=%0d got vld=%b data=%h want vld=1 data=%h",
                 i, deq_valid8, deq_bits8, vals[i]);
      end
      tick();
    end
    deq_ready8 = 1'b0;
  endtask

  task automatic test_reset_midstream();
    deq_ready8 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      enq_valid8 = 1'b1;
      enq_bits8  = 8'(i);
      tick();
    end
    total++;
    if (count8 !== 3'd3) begin
      bad++;
      $display("FAIL pre_reset_count got=%0d want=3", count8);
    end
    enq_bits8  = 8'h77;
    deq_ready8 = 1'b1;
    reset      = 1'b1;
    tick();
    reset      = 1'b0;
    enq_valid8 = 1'b0;
    deq_ready8 = 1'b0;
    total++;
    if (count8 !== 3'd0 || deq_valid8 !== 1'b0 || enq_ready8 !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset got cnt=%0d vld=%b rdy=%b want cnt=0 vld=0 rdy=1",
               count8, deq_valid8, enq_ready8);
    end
    enq_valid8 = 1'b1;
    enq_bits8  = 8'h5A;
    tick();
    enq_valid8 = 1'b0;
    total++;
    if (deq_valid8 !== 1'b1 || deq_bits8 !== 8'h5A || count8 !== 3'd1) begin
      bad++;
      $display("FAIL post_reset_first got vld=%b data=%h cnt=%0d want vld=1 data=5a cnt=1",
               deq_valid8, deq_bits8, count8);
    end
    deq_ready8 = 1'b1;
    tick();
    deq_ready8 = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] model [$];
    logic       ef;
    logic       df;
    model.delete();
    for (int c = 0; c < 1000; c++) begin
      enq_valid8 = ($urandom_range(0, 3) != 0);
      enq_bits8  = 8'($urandom);
      deq_ready8 = ($urandom_range(0, 2) != 0);
      total++;
      if (enq_ready8 !== (model.size() < 4) || deq_valid8 !== (model.size() > 0) ||
          count8 !== 3'(model.size()) || (model.size() > 0 && deq_bits8 !== model[0])) begin
        bad++;
        $display("FAIL random c=%0d got rdy=%b vld=%b cnt=%0d head=%h want cnt=%0d head=%h",
                 c, enq_ready8, deq_valid8, count8, deq_bits8, model.size(),
                 (model.size() > 0) ? model[0] : 8'h00);
      end
      ef = enq_valid8 && (model.size() < 4);
      df = deq_ready8 && (model.size() > 0);
      tick();
      if (df) void'(model.pop_front());
      if (ef) model.push_back(enq_bits8);
    end
    enq_valid8 = 1'b0;
    deq_ready8 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    deq_ready8 = 1'b0;
    total++;
    if (count8 !== 3'd0) begin
      bad++;
      $display("FAIL random_flush got cnt=%0d want=0", count8);
    end
  endtask

  task automatic test_shim_chain();
    shim_in_bits = 1'b0;
    deq_ready1   = 1'b0;
    total++;
    if (deq_valid1 !== 1'b0 || enq_ready1 !== 1'b1) begin
      bad++;
      $display("FAIL shim_idle got vld=%b rdy=%b want vld=0 rdy=1", deq_valid1, enq_ready1);
    end
    shim_valid = 1'b1;
    tick();
    shim_valid = 1'b0;
    total++;
    if (deq_valid1 !== 1'b1 || deq_bits1 !== 1'b1 || count1 !== 3'd1) begin
      bad++;
      $display("FAIL shim_chain got vld=%b data=%b cnt=%0d want vld=1 data=1 cnt=1",
               deq_valid1, deq_bits1, count1);
    end
    deq_ready1 = 1'b1;
    tick();
    deq_ready1 = 1'b0;
    total++;
    if (deq_valid1 !== 1'b0 || count1 !== 3'd0) begin
      bad++;
      $display("FAIL shim_drain got vld=%b cnt=%0d want vld=0 cnt=0", deq_valid1, count1);
    end
  endtask

  initial begin
    test_reset();
    test_fill_hold_drain();
    test_stream();
    test_full_simultaneous();
    test_reset_midstream();
    test_random();
    test_shim_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
